// File: rtl/inst_enc.sv
// inst_enc -- RV32I instruction encoder feeding a small output FIFO.
//
// Takes decoded instruction fields, packs them into a 32-bit RV32I word and
// buffers the result in a DEPTH-entry FIFO.  Each word leaves the FIFO with
// the byte address it will occupy in instruction memory.
//
// Optional feature macro: INST_ENC_RANGE_CHECK_EN
//   defined   : err goes high (sticky until reset) when a pushed immediate
//               cannot be represented by its format, or the kind is illegal.
//               The word is still encoded (truncated) and pushed.
//   undefined : no checking logic, err is tied low.
//
// Parameters
//   DEPTH  : FIFO entries (power of two, >= 2)
//   ADDR_W : width of out_addr
//   BASE   : out_addr value after reset
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   : request handshake
//   in_kind               : 0 IMM 1 REG 2 LOAD 3 STORE 4 LUI 5 AUIPC 6 JAL
//                           7 JALR 8 BRANCH 9 SYSTEM, 10..15 illegal (NOP)
//   in_rd/in_rs1/in_rs2   : register ids
//   in_funct3, in_sub     : funct3 and funct7[5]
//   in_imm                : byte immediate (U-type: low 12 bits zero)
//   out_valid / out_ready : head-of-FIFO handshake
//   out_inst, out_addr    : head word and its byte address
//   err                   : sticky encode error
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high.  A producer holding valid keeps its
// payload stable until the transfer; ready may be any function of state but
// never depends on the same-cycle valid.  in_ready = (count != DEPTH), so a
// full FIFO refuses a push even while it is being popped.

module inst_enc #(
  parameter int unsigned          DEPTH  = 4,
  parameter int unsigned          ADDR_W = 32,
  parameter logic [ADDR_W-1:0]    BASE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_sub,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [3:0] K_IMM    = 4'd0;
  localparam logic [3:0] K_REG    = 4'd1;
  localparam logic [3:0] K_LOAD   = 4'd2;
  localparam logic [3:0] K_STORE  = 4'd3;
  localparam logic [3:0] K_LUI    = 4'd4;
  localparam logic [3:0] K_AUIPC  = 4'd5;
  localparam logic [3:0] K_JAL    = 4'd6;
  localparam logic [3:0] K_JALR   = 4'd7;
  localparam logic [3:0] K_BRANCH = 4'd8;
  localparam logic [3:0] K_SYSTEM = 4'd9;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        is_shift;

  // slli / srli / srai carry a 5-bit shamt plus funct7 instead of imm[11:0]
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    enc_word = NOP;
    case (in_kind)
      K_IMM: begin
        if (is_shift)
          enc_word = {1'b0, in_sub, 5'b00000, in_imm[4:0], in_rs1, in_funct3,
                      in_rd, OP_IMM};
        else
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
      end
      K_REG:
        enc_word = {1'b0, in_sub, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd,
                    OP_REG};
      K_LOAD:
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      K_STORE:
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                    OP_STORE};
      K_LUI:
        enc_word = {in_imm[31:12], in_rd, OP_LUI};
      K_AUIPC:
        enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
      K_JAL:
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, OP_JAL};
      K_JALR:
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      K_BRANCH:
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], OP_BRANCH};
      K_SYSTEM:
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_SYSTEM};
      default:
        enc_word = NOP;
    endcase
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_inst  = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_addr <= BASE;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_word;
        wr_ptr      <= wr_ptr + 1'b1;  // power-of-two depth wraps naturally
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_addr <= out_addr + ADDR_W'(4);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Immediate range check
  // ---------------------------------------------------------------------
`ifdef INST_ENC_RANGE_CHECK_EN
  logic enc_bad;
  logic fit12;
  logic fit13;
  logic fit21;

  // An n-bit signed value has bits [31:n-1] all equal
  assign fit12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fit13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign fit21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    enc_bad = 1'b0;
    case (in_kind)
      K_IMM:    enc_bad = is_shift ? (|in_imm[31:5]) : !fit12;
      K_REG:    enc_bad = 1'b0;
      K_LOAD:   enc_bad = !fit12;
      K_STORE:  enc_bad = !fit12;
      K_LUI:    enc_bad = |in_imm[11:0];
      K_AUIPC:  enc_bad = |in_imm[11:0];
      K_JAL:    enc_bad = !fit21 || in_imm[0];
      K_JALR:   enc_bad = !fit12;
      K_BRANCH: enc_bad = !fit13 || in_imm[0];
      K_SYSTEM: enc_bad = |in_imm[31:12];
      default:  enc_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (push && enc_bad)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_enc.sv
// tb_inst_enc -- self-checking bench for inst_enc.
// Expected words are queued when the bench's push is accepted and compared,
// together with a running expected address, whenever the DUT hands a word
// to the consumer.  Built with or without INST_ENC_RANGE_CHECK_EN.

module tb_inst_enc;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        in_sub;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        rand_rdy;
  logic        rdy_cmd;

  inst_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_sub(in_sub), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- consumer ready driver ----------------
  always @(posedge clock) begin
    #2;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    else          out_ready = rdy_cmd;
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      exp_addr = BASE;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("inst", out_inst, e);
        check("addr", out_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic [3:0] kind, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic sub,
                           input logic [31:0] imm, input logic [31:0] exp);
    bit ok;
    ok = 0;
    in_kind = kind; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_sub = sub; in_imm = imm;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock);
      if (in_ready) ok = 1;
      @(posedge clock);
    end
    if (ok) exp_q.push_back(exp);
    else    check("push_timeout", 32'd1, 32'd0);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] exp_err;
    reset = 1'b1; in_valid = 1'b0; rand_rdy = 1'b0; rdy_cmd = 1'b0;
    out_ready = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_sub = 1'b0; in_imm = '0;
    exp_addr = BASE;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst",  out_inst,       32'd0);
    check("rst_out_addr",  out_addr,       BASE);
    check("rst_err",       32'(err),       32'd0);
    @(posedge clock); #3;
    reset = 1'b0;
    rdy_cmd = 1'b1;
    @(posedge clock); #1;

    // addi then sub; first word visible the cycle after acceptance
    push_word(4'd0, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 32'h0050_0093);
    @(negedge clock);
    check("latency_valid", 32'(out_valid), 32'd1);
    @(posedge clock); #1;
    push_word(4'd1, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 32'h4020_81B3);
    // store, srai, jal, beq back to back
    push_word(4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8, 32'h0020_A423);
    push_word(4'd0, 5'd5, 5'd5, 5'd0, 3'b101, 1'b1, 32'd3, 32'h4032_D293);
    push_word(4'd6, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h800, 32'h0010_00EF);
    push_word(4'd8, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFFC,
              32'hFE20_8EE3);
    // lui / jalr (funct3 forced to 000) / load
    push_word(4'd4, 5'd7, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000,
              32'h1234_53B7);
    push_word(4'd7, 5'd1, 5'd6, 5'd0, 3'b111, 1'b0, 32'd16, 32'h0103_00E7);
    push_word(4'd2, 5'd4, 5'd2, 5'd0, 3'b100, 1'b0, 32'hFFFF_FFFF,
              32'hFFF1_4203);
    drain();
    check("err_legal", 32'(err), 32'd0);

    // fill the FIFO with the consumer stalled
    rdy_cmd = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < DEPTH; i++)
      push_word(4'd0, 5'(i + 1), 5'd0, 5'd0, 3'b000, 1'b0, 32'(i + 1),
                32'((i + 1) << 20) | 32'((i + 1) << 7) | 32'h13);
    fork
      push_word(4'd0, 5'd9, 5'd0, 5'd0, 3'b000, 1'b0, 32'd9, 32'h0090_0493);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          check("full_in_ready", 32'(in_ready), 32'd0);
          check("hold_inst", out_inst, 32'h0010_0093);
          check("hold_addr", out_addr, exp_addr);
        end
        @(posedge clock); #1;
        rdy_cmd = 1'b1;
      end
    join
    drain();

    // random REG stream with a randomly stalling consumer
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [4:0] rd, rs1, rs2;
      logic [2:0] f3;
      logic       sb;
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      f3  = 3'($urandom_range(0, 7));
      sb  = 1'($urandom_range(0, 1));
      push_word(4'd1, rd, rs1, rs2, f3, sb, 32'($urandom),
                (32'(sb) << 30) + (32'(rs2) << 20) + (32'(rs1) << 15) +
                (32'(f3) << 12) + (32'(rd) << 7) + 32'h33);
    end
    drain();
    rand_rdy = 1'b0;
    rdy_cmd  = 1'b1;
    @(posedge clock); #1;

    // out-of-range immediate and illegal kind
`ifdef INST_ENC_RANGE_CHECK_EN
    exp_err = 32'd1;
`else
    exp_err = 32'd0;
`endif
    push_word(4'd0, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048, 32'h8000_0093);
    @(negedge clock);
    check("err_range", 32'(err), exp_err);
    @(posedge clock); #1;
    push_word(4'd12, 5'd3, 5'd4, 5'd5, 3'b111, 1'b1, 32'hFFFF_FFFF,
              32'h0000_0013);
    push_word(4'd1, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 32'd0, 32'h0010_80B3);
    drain();
    check("err_sticky", 32'(err), exp_err);

    // reset with three words buffered
    rdy_cmd = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++)
      push_word(4'd9, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0, 32'h0000_0073);
    @(negedge clock);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_addr",  out_addr,       BASE);
    check("mid_rst_err",   32'(err),       32'd0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    rdy_cmd = 1'b1;
    @(posedge clock); #1;
    push_word(4'd5, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'hABCD_E000,
              32'hABCD_E117);
    @(negedge clock);
    check("post_rst_addr", out_addr, BASE);
    drain();
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
